map_updater: RTL and testbench
==============================

MAP_UPDATER -- requirements
Module: map_updater

Interface
REQ-001 Parameter COLS, default 20, tile columns (32-px tiles across 640 px).
REQ-002 Parameter ROWS, default 15, tile rows (32-px tiles down 480 px).
REQ-003 Parameter DEPTH, default 4, request FIFO entries (power of two).
REQ-004 Clk  input  1  sole clock, all state on rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  tile-write request present.
REQ-007 req_ready  output  1  request accepted when req_valid && req_ready at rising edge.
REQ-008 req_x  input  5  tile column.
REQ-009 req_y  input  4  tile row.
REQ-010 req_tile  input  3  tile code: 0 empty, 1 steel, 2 brick, 3/4 gold; 5-7 illegal.
REQ-011 clear_start  input  1  single-cycle pulse requesting whole-map fill.
REQ-012 fill_tile  input  3  fill code, sampled with clear_start.
REQ-013 vblank  input  1  commit window; map changes only while high.
REQ-014 map  output  COLS*ROWS x 3  registered tile map, index = y*COLS + x, read by the colour mapper.
REQ-015 busy  output  1  high when state != IDLE or FIFO non-empty.
REQ-016 err  output  1  one-cycle pulse on a rejected request.

Function
REQ-017 States IDLE, DRAIN, CLEAR; IDLE->DRAIN when FIFO non-empty; DRAIN->IDLE when FIFO empty after pop; any->CLEAR on accepted clear_start; CLEAR->IDLE after index COLS*ROWS-1 written.
REQ-018 req_ready = FIFO not full and state != CLEAR and clear_start low.
REQ-019 Accepted request with req_x >= COLS, req_y >= ROWS, or req_tile > 4: consumed, not queued, err pulses the following cycle, map unchanged.
REQ-020 Legal accepted request pushed with precomputed index y*COLS+x (9 bits) and code.
REQ-021 In DRAIN, one entry popped and written to map per cycle in which vblank=1; no pop while vblank=0.
REQ-022 Minimum latency: accepted at edge N into empty FIFO with vblank=1 during cycle N..N+1 -> map entry updated at edge N+1.
REQ-023 Simultaneous push and pop in same cycle legal; occupancy unchanged; full FIFO with pop still shows req_ready=0 that cycle (ready from registered count).
REQ-024 Two queued writes to same index commit in acceptance order; last one wins.
REQ-025 clear_start honoured in any state; flushes FIFO, captures fill_tile (code > 4 -> fill with 0 and pulse err), index counter to 0.
REQ-026 In CLEAR, one tile written per vblank=1 cycle, counter increments; paused, not reset, when vblank=0.
REQ-027 clear_start during CLEAR restarts fill at index 0 with newly captured fill_tile.
REQ-028 req_valid during CLEAR is not accepted (ready low); requester must hold.
REQ-029 map entries not targeted in a cycle hold value.

Reset
REQ-030 Reset high at edge: all map entries 0, FIFO empty, state IDLE, counter 0, busy 0, err 0; req_ready 1 the following cycle.
REQ-031 Reset mid-CLEAR or mid-DRAIN aborts immediately; pending entries discarded; no partial write after reset edge.
REQ-032 Reset dominates clear_start and req_valid in the same cycle.

Verification
REQ-033 vblank=1, write (x=3,y=2,tile=2) -> map[43]=2 one edge later, busy back to 0 next cycle.
REQ-034 vblank=0, push 4 requests -> req_ready=0 after 4th, map unchanged; raise vblank -> 4 writes on 4 consecutive edges, in order.
REQ-035 Request (x=20,y=0) and (x=0,y=0,tile=6) -> err pulses one cycle each, map[0] unchanged.
REQ-036 clear_start fill_tile=1, vblank toggling 1/0 per cycle -> all 300 entries =1 after 600 cycles; req_ready 0 throughout; busy falls after last write.
REQ-037 Reset asserted at index 150 of a fill -> all entries 0, state IDLE, later requests committed normally.
REQ-038 Two writes to index 5 (tile 2 then 3) queued -> final map[5]=3.

Source files
------------

// File: rtl/map_updater.sv
// map_updater: queues tile-write requests and commits them to a registered
// tile map during vblank, and fills the whole map from a single
// clear_start pulse.
//
// Ports
//   clk, reset          sole clock; synchronous active-high reset
//   req_valid/req_ready tile-write handshake (req_x, req_y, req_tile)
//   clear_start         one-cycle pulse; fills the map with fill_tile
//   vblank              commit window; the map changes only while high
//   map                 COLS*ROWS 3-bit codes, entry i at map[i*3 +: 3]
//   busy                high while a fill is running or requests are queued
//   err                 one-cycle pulse after a rejected request or bad fill code
//
// state | meaning
// IDLE  | FIFO empty, nothing to commit
// DRAIN | FIFO holds requests; one is committed per vblank cycle
// CLEAR | whole-map fill in progress; requests are held off
module map_updater #(
    parameter int COLS  = 20,
    parameter int ROWS  = 15,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [4:0]                 req_x,
    input  logic [3:0]                 req_y,
    input  logic [2:0]                 req_tile,
    input  logic                       clear_start,
    input  logic [2:0]                 fill_tile,
    input  logic                       vblank,
    output logic [COLS*ROWS*3-1:0]     map,
    output logic                       busy,
    output logic                       err
);

    localparam int NT = COLS * ROWS;
    localparam int IW = $clog2(NT);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [IW-1:0] LAST = IW'(NT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] CLEAR = 2'd2;

    logic [1:0]      state;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [IW+2:0]   fifo_mem [DEPTH];
    logic [IW-1:0]   clr_idx;
    logic [2:0]      fill_code;
    logic [2:0]      tiles [NT];

    logic            accept;
    logic            illegal;
    logic            push;
    logic            pop;
    logic [IW-1:0]   req_idx;
    logic            wr_en;
    logic [IW-1:0]   wr_idx;
    logic [2:0]      wr_code;

    // Ready comes from the registered count, so a full FIFO stays not-ready
    // even in a cycle where an entry is being popped.
    assign req_ready = (count != CW'(DEPTH)) && (state != CLEAR) && !clear_start;
    assign accept    = req_valid && req_ready;
    assign illegal   = (int'(req_x) >= COLS) || (int'(req_y) >= ROWS) || (req_tile > 3'd4);
    assign req_idx   = IW'(req_y) * IW'(COLS) + IW'(req_x);
    assign push      = accept && !illegal;
    assign pop       = (state == DRAIN) && vblank && (count != '0) && !clear_start;
    assign busy      = (state != IDLE) || (count != '0);

    always_comb begin
        count_next = count + CW'(push) - CW'(pop);
    end

    // Pop and fill writes are mutually exclusive (DRAIN vs CLEAR), so the map
    // needs only one write port.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_code = '0;
        if (pop) begin
            wr_en   = 1'b1;
            wr_idx  = fifo_mem[rd_ptr][IW+2:3];
            wr_code = fifo_mem[rd_ptr][2:0];
        end else if ((state == CLEAR) && vblank && !clear_start) begin
            wr_en   = 1'b1;
            wr_idx  = clr_idx;
            wr_code = fill_code;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {req_idx, req_tile};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            clr_idx   <= '0;
            fill_code <= '0;
            err       <= 1'b0;
        end else begin
            err <= (accept && illegal) || (clear_start && (fill_tile > 3'd4));
            if (clear_start) begin
                // Flush queued requests and (re)start the fill from index 0.
                state     <= CLEAR;
                count     <= '0;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                clr_idx   <= '0;
                fill_code <= (fill_tile > 3'd4) ? 3'd0 : fill_tile;
            end else if (state == CLEAR) begin
                if (vblank) begin
                    if (clr_idx == LAST) begin
                        state   <= IDLE;
                        clr_idx <= '0;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count_next;
                // Entering DRAIN on the push edge lets the entry commit on
                // the very next edge.
                state <= (count_next != '0) ? DRAIN : IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NT; i++) begin
                tiles[i] <= 3'd0;
            end
        end else if (wr_en) begin
            tiles[wr_idx] <= wr_code;
        end
    end

    for (genvar g = 0; g < NT; g++) begin : g_map
        assign map[g*3 +: 3] = tiles[g];
    end

endmodule

// File: tb/tb_map_updater.sv
// Directed bench for map_updater: single writes, queued bursts, illegal
// requests, ordering of same-index writes, fills with vblank pauses,
// fill restart, and reset in the middle of a fill.
module tb_map_updater;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [4:0]   req_x;
    logic [3:0]   req_y;
    logic [2:0]   req_tile;
    logic         clear_start;
    logic [2:0]   fill_tile;
    logic         vblank;
    logic [899:0] map;
    logic         busy;
    logic         err;

    int n_checks = 0;
    int n_pass   = 0;

    map_updater dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_tile    (req_tile),
        .clear_start (clear_start),
        .fill_tile   (fill_tile),
        .vblank      (vblank),
        .map         (map),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int x, input int y, input int t);
        req_valid = 1'b1;
        req_x     = 5'(x);
        req_y     = 4'(y);
        req_tile  = 3'(t);
        tick();
        req_valid = 1'b0;
    endtask

    function automatic int tile_at(input int i);
        return int'(map[i*3 +: 3]);
    endfunction

    function automatic int count_not(input int v);
        int n = 0;
        for (int i = 0; i < 300; i++) begin
            if (tile_at(i) != v) n++;
        end
        return n;
    endfunction

    initial begin
        int ready_seen;

        reset = 1'b1; req_valid = 1'b0; req_x = '0; req_y = '0; req_tile = '0;
        clear_start = 1'b0; fill_tile = '0; vblank = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(err), 0);
        check("rst_ready", int'(req_ready), 1);
        check("rst_map", count_not(0), 0);

        // single write, minimum latency
        vblank = 1'b1;
        push(3, 2, 2);
        check("single_pending", tile_at(43), 0);
        check("single_busy_hi", int'(busy), 1);
        tick();
        check("single_map43", tile_at(43), 2);
        check("single_busy_lo", int'(busy), 0);

        // queue four while vblank low, fifth held while full
        vblank = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("burst_ready", int'(req_ready), 1);
            push(k, 1, k + 1);
        end
        check("burst_full_ready", int'(req_ready), 0);
        check("burst_nochange", count_not(0) - 1, 0);
        req_valid = 1'b1; req_x = 5'd4; req_y = 4'd1; req_tile = 3'd1;
        vblank = 1'b1;
        tick();
        check("burst_w0", tile_at(20), 1);
        check("burst_w1_pending", tile_at(21), 0);
        tick();
        req_valid = 1'b0;
        check("burst_w1", tile_at(21), 2);
        check("burst_w2_pending", tile_at(22), 0);
        tick();
        check("burst_w2", tile_at(22), 3);
        tick();
        check("burst_w3", tile_at(23), 4);
        check("burst_w4_pending", tile_at(24), 0);
        tick();
        check("burst_w4", tile_at(24), 1);
        check("burst_busy", int'(busy), 0);

        // illegal requests
        push(0, 0, 1);
        tick();
        check("ill_map0_set", tile_at(0), 1);
        push(20, 0, 2);
        check("ill_x_err", int'(err), 1);
        check("ill_x_busy", int'(busy), 0);
        tick();
        check("ill_x_err_drop", int'(err), 0);
        push(0, 0, 6);
        check("ill_t_err", int'(err), 1);
        tick();
        check("ill_t_err_drop", int'(err), 0);
        push(0, 15, 3);
        check("ill_y_err", int'(err), 1);
        tick();
        check("ill_map0_kept", tile_at(0), 1);
        check("ill_map300_none", tile_at(299), 0);

        // same index twice, last wins
        vblank = 1'b0;
        push(5, 0, 2);
        push(5, 0, 3);
        vblank = 1'b1;
        tick();
        check("dup_first", tile_at(5), 2);
        tick();
        check("dup_last", tile_at(5), 3);

        // fill with vblank toggling
        clear_start = 1'b1; fill_tile = 3'd1;
        tick();
        clear_start = 1'b0;
        check("fill_busy", int'(busy), 1);
        check("fill_err", int'(err), 0);
        ready_seen = 0;
        for (int i = 0; i < 600; i++) begin
            vblank = (i % 2 == 0);
            if (i <= 598 && req_ready) ready_seen++;
            tick();
            if (i == 300) check("fill_mid_idx149", tile_at(149), 1);
            if (i == 300) check("fill_mid_idx151", tile_at(151), 0);
            if (i == 596) check("fill_busy_before_last", int'(busy), 1);
            if (i == 598) check("fill_busy_after_last", int'(busy), 0);
        end
        check("fill_ready_low", ready_seen, 0);
        check("fill_all_one", count_not(1), 0);

        // reset at index 150 of a fill
        vblank = 1'b1;
        clear_start = 1'b1; fill_tile = 3'd3;
        tick();
        clear_start = 1'b0;
        repeat (150) tick();
        check("part_idx149", tile_at(149), 3);
        check("part_idx150", tile_at(150), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_map", count_not(0), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_ready", int'(req_ready), 1);
        tick();
        check("abort_no_write", tile_at(150), 0);
        push(7, 3, 4);
        tick();
        check("after_abort_write", tile_at(67), 4);

        // restart mid-fill with an illegal fill code
        clear_start = 1'b1; fill_tile = 3'd2;
        tick();
        clear_start = 1'b0;
        repeat (10) tick();
        check("restart_pre9", tile_at(9), 2);
        check("restart_pre10", tile_at(10), 0);
        clear_start = 1'b1; fill_tile = 3'd7;
        tick();
        clear_start = 1'b0;
        check("restart_err", int'(err), 1);
        repeat (300) tick();
        check("restart_all_zero", count_not(0), 0);
        check("restart_busy", int'(busy), 0);

        // reset dominates clear_start and req_valid
        reset = 1'b1; clear_start = 1'b1; fill_tile = 3'd4;
        req_valid = 1'b1; req_x = 5'd1; req_y = 4'd0; req_tile = 3'd2;
        tick();
        reset = 1'b0; clear_start = 1'b0; req_valid = 1'b0;
        check("dom_busy", int'(busy), 0);
        check("dom_err", int'(err), 0);
        tick();
        check("dom_map", count_not(0), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
